cdc_bus_src_stage: RTL

Source-domain front end for the bus handshake CDC path. It buffers words arriving on a valid/ready stream in a small FIFO and loads one word at a time into a hold register. It then pulses the request into the handshake controller's source port, keeping the hold register stable until the controller reports ready again. The destination domain samples the hold register only while its valid is asserted.

---
 rtl/cdc_bus_pkg.sv | 14 +
 rtl/cdc_src_fifo.sv | 57 +++++
 rtl/cdc_bus_src_stage.sv | 99 +++++++++
 3 files changed

// File: rtl/cdc_bus_pkg.sv
// Shared types and default sizing for the bus handshake CDC source stage.
package cdc_bus_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_DEPTH  = 4;
  localparam int unsigned DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } src_state_e;

endpackage

// File: rtl/cdc_src_fifo.sv
// Synchronous FIFO with registered level, full and empty flags.
module cdc_src_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                      src_clk,
  input  logic                      src_rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DATA_W-1:0]         wr_data,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level_nxt;

  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge src_clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + LVL_W'(1);
      2'b01:   level_nxt = level - LVL_W'(1);
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge src_clk or posedge src_rst) begin
    if (src_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_nxt;
      full  <= (level_nxt == LVL_W'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

endmodule

// File: rtl/cdc_bus_src_stage.sv
// Source-domain front end of the bus handshake CDC: FIFO, hold register, request FSM.
// Optional hold_par output enabled by defining CDC_SRC_PARITY_EN.
module cdc_bus_src_stage
  import cdc_bus_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic                   src_clk,
  input  logic                   src_rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   hs_req,
  input  logic                   hs_ready,
  output logic [DATA_W-1:0]      hold_data,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       xfer_cnt
`ifdef CDC_SRC_PARITY_EN
  ,
  output logic                   hold_par
`endif
);

  src_state_e        state;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] head;
  logic              push_c;
  logic              pop_c;
  logic              done_c;

  assign in_ready = !fifo_full;
  assign push_c   = in_valid && !fifo_full;
  assign done_c   = (state == WAIT) && hs_ready;
  // A launch may chain directly onto the completion of the previous transfer.
  assign pop_c    = !fifo_empty && hs_ready && ((state == IDLE) || (state == WAIT));

  cdc_src_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .src_clk (src_clk),
    .src_rst (src_rst),
    .push    (push_c),
    .pop     (pop_c),
    .wr_data (in_data),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  always_ff @(posedge src_clk or posedge src_rst) begin
    if (src_rst) begin
      state     <= IDLE;
      hs_req    <= 1'b0;
      hold_data <= '0;
      busy      <= 1'b0;
      xfer_cnt  <= '0;
    end else begin
      hs_req <= pop_c;
      if (pop_c)  hold_data <= head;
      if (done_c) xfer_cnt  <= xfer_cnt + CNT_W'(1);
      case (state)
        IDLE: begin
          if (pop_c) begin
            state <= REQ;
            busy  <= 1'b1;
          end
        end
        REQ: state <= WAIT;
        WAIT: begin
          if (pop_c) begin
            state <= REQ;
          end else if (hs_ready) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CDC_SRC_PARITY_EN
  // Parity tracks the word captured into hold_data on the same edge.
  always_ff @(posedge src_clk or posedge src_rst) begin
    if (src_rst)    hold_par <= 1'b0;
    else if (pop_c) hold_par <= ^head;
  end
`endif

endmodule
